// File: rtl/cpc_ram_bank_ctrl.sv
// CPC RAM expansion banking controller: OUT &7Fxx (D[7:6]=11) selects mode/bank and the SRAM takes over mapped quadrants.
// Define CFG_READBACK_EN to return the config on IN from ports with A15=0, A14=0; otherwise D is never driven.
module cpc_ram_bank_ctrl #(
   parameter int NUM_BANK_BITS = 3
) (
   input  logic                     CLK,
   input  logic                     RESET_B,
   input  logic [7:0]               A,
   inout  wire  [7:0]               D,
   input  logic                     MREQ_B,
   input  logic                     IOREQ_B,
   input  logic                     RD_B,
   input  logic                     WR_B,
   input  logic                     M1_B,
   input  logic                     RFSH_B,
   output logic                     RAMDIS,
   output logic [NUM_BANK_BITS+1:0] HIADR,
   output logic                     RAMCS_B,
   output logic                     RAMOE_B,
   output logic                     RAMWE_B
);
   localparam int HW = NUM_BANK_BITS + 2;

   typedef enum logic {IO_IDLE, IO_DONE} io_state_t;
   typedef enum logic [1:0] {W_IDLE, W_ARM, W_HOLD} w_state_t;

   io_state_t                io_state_reg, io_state_next;
   w_state_t                 w_state_reg, w_state_next;
   logic [2:0]               mode_reg, mode_next;
   logic [NUM_BANK_BITS-1:0] bank_reg, bank_next, bank_load;
   logic [HW-1:0]            wr_addr_reg, wr_addr_next, map_addr;
   logic [1:0]               page;
   logic                     io_wr, mapped, w_active, sel;
   logic                     unused_addr;

   assign io_wr = !IOREQ_B && !WR_B && M1_B && !A[7] && (D[7:6] == 2'b11);

   // Bank bits above the 512K range come inverted from A8 upwards.
   assign bank_load[2:0] = D[5:3];
   generate
      for (genvar gi = 3; gi < NUM_BANK_BITS; gi++) begin : g_bank_hi
         assign bank_load[gi] = ~A[gi-3];
      end
   endgenerate
   assign unused_addr = &{1'b0, A};

   always_comb begin
      mapped = 1'b0;
      page   = 2'b00;
      case (mode_reg)
         3'd1, 3'd3: begin
            mapped = (A[7:6] == 2'b11);
            page   = 2'b11;
         end
         3'd2: begin
            mapped = 1'b1;
            page   = A[7:6];
         end
         3'd4, 3'd5, 3'd6, 3'd7: begin
            mapped = (A[7:6] == 2'b01);
            page   = mode_reg[1:0];
         end
         default: ;
      endcase
   end

   assign map_addr = {bank_reg, page};
   assign w_active = (w_state_reg != W_IDLE);

   // An armed write keeps the mapping captured when it started, even if cfg changes under it.
   assign sel     = (mapped || w_active) && !MREQ_B && RFSH_B;
   assign RAMDIS  = sel;
   assign HIADR   = sel ? (w_active ? wr_addr_reg : map_addr) : '0;
   assign RAMCS_B = !sel;
   assign RAMOE_B = !(sel && !RD_B);
   assign RAMWE_B = !(w_active && !WR_B);

   always_comb begin
      io_state_next = io_state_reg;
      mode_next     = mode_reg;
      bank_next     = bank_reg;
      if (RFSH_B) begin
         case (io_state_reg)
            IO_IDLE: begin
               if (io_wr) begin
                  io_state_next = IO_DONE;
                  mode_next     = D[2:0];
                  bank_next     = bank_load;
               end
            end
            IO_DONE: begin
               if (IOREQ_B) io_state_next = IO_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      w_state_next = w_state_reg;
      wr_addr_next = wr_addr_reg;
      if (RFSH_B) begin
         case (w_state_reg)
            W_IDLE: begin
               if (sel && !WR_B) begin
                  w_state_next = W_ARM;
                  wr_addr_next = map_addr;
               end
            end
            W_ARM:   w_state_next = W_HOLD;
            W_HOLD: begin
               if (MREQ_B) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
         io_state_reg <= IO_IDLE;
         w_state_reg  <= W_IDLE;
         mode_reg     <= '0;
         bank_reg     <= '0;
         wr_addr_reg  <= '0;
      end else begin
         io_state_reg <= io_state_next;
         w_state_reg  <= w_state_next;
         mode_reg     <= mode_next;
         bank_reg     <= bank_next;
         wr_addr_reg  <= wr_addr_next;
      end
   end

`ifdef CFG_READBACK_EN
   logic rb_en;
   assign rb_en = RESET_B && !IOREQ_B && !RD_B && M1_B && !A[7] && !A[6];
   assign D     = rb_en ? {2'b11, bank_reg[2:0], mode_reg} : 8'hzz;
`else
   assign D = 8'hzz;
`endif

endmodule

// File: tb/tb_cpc_ram_bank_ctrl.sv
// Directed Z80 bus cycles against two controller instances (3 and 4 bank bits) with a per-cycle reference model.
`timescale 1ns/1ps
module tb_cpc_ram_bank_ctrl;
   logic       CLK = 1'b0;
   logic       RESET_B = 1'b1;
   logic [7:0] A = 8'h00;
   logic       MREQ_B = 1'b1, IOREQ_B = 1'b1, RD_B = 1'b1, WR_B = 1'b1, M1_B = 1'b1, RFSH_B = 1'b1;
   logic [7:0] tb_d = 8'h00;
   logic       tb_d_oe = 1'b0;
   wire  [7:0] d_bus;

   logic       ramdis3, cs3, oe3, we3;
   logic [4:0] hiadr3;
   logic       ramdis4, cs4, oe4, we4;
   logic [5:0] hiadr4;

   int total = 0;
   int bad = 0;
   int m_mode = 0, m_bank_lo = 0, m_port_a = 255;
   int we_edges = 0;
   int we_falls = 0;

   assign d_bus = tb_d_oe ? tb_d : 8'hzz;
   for (genvar gi = 0; gi < 8; gi++) begin : g_pu
      pullup (d_bus[gi]);
   end

   always #5 CLK = ~CLK;

   cpc_ram_bank_ctrl #(.NUM_BANK_BITS(3)) u_dut3 (
      .CLK(CLK), .RESET_B(RESET_B), .A(A), .D(d_bus),
      .MREQ_B(MREQ_B), .IOREQ_B(IOREQ_B), .RD_B(RD_B), .WR_B(WR_B), .M1_B(M1_B), .RFSH_B(RFSH_B),
      .RAMDIS(ramdis3), .HIADR(hiadr3), .RAMCS_B(cs3), .RAMOE_B(oe3), .RAMWE_B(we3)
   );

   cpc_ram_bank_ctrl #(.NUM_BANK_BITS(4)) u_dut4 (
      .CLK(CLK), .RESET_B(RESET_B), .A(A), .D(d_bus),
      .MREQ_B(MREQ_B), .IOREQ_B(IOREQ_B), .RD_B(RD_B), .WR_B(WR_B), .M1_B(M1_B), .RFSH_B(RFSH_B),
      .RAMDIS(ramdis4), .HIADR(hiadr4), .RAMCS_B(cs4), .RAMOE_B(oe4), .RAMWE_B(we4)
   );

   task automatic cmp(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // SRAM page for the current address under the model cfg, -1 when internal RAM answers.
   function automatic int map_page(input logic [7:0] a);
      int q;
      q = int'(a[7:6]);
      if (m_mode == 2) return q;
      if ((m_mode == 1 || m_mode == 3) && q == 3) return 3;
      if (m_mode >= 4 && q == 1) return m_mode - 4;
      return -1;
   endfunction

   function automatic int exp_hi(input int nbb, input int pg);
      int bank;
      bank = m_bank_lo + (((~m_port_a) & ((1 << (nbb - 3)) - 1)) << 3);
      return bank * 4 + pg;
   endfunction

   // Edges seen since WR_B fell in a selected cycle; RAMWE_B is low from the first one.
   always @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B || WR_B)
         we_edges <= 0;
      else if (we_edges > 0 || (!MREQ_B && RFSH_B && map_page(A) >= 0))
         we_edges <= we_edges + 1;
   end

   always @(negedge we3) we_falls++;

   always @(negedge CLK) begin : compare
      int  pg;
      bit  s;
      bit  we_low;
      pg     = map_page(A);
      s      = RESET_B && !MREQ_B && RFSH_B && (pg >= 0);
      we_low = RESET_B && !WR_B && (we_edges > 0);
      cmp("cyc_ramdis3", int'(ramdis3), int'(s));
      cmp("cyc_ramcs3", int'(cs3), int'(!s));
      cmp("cyc_ramoe3", int'(oe3), int'(!(s && !RD_B)));
      cmp("cyc_hiadr3", int'(hiadr3), s ? exp_hi(3, pg) : 0);
      cmp("cyc_ramwe3", int'(we3), int'(!we_low));
      cmp("cyc_ramdis4", int'(ramdis4), int'(s));
      cmp("cyc_hiadr4", int'(hiadr4), s ? exp_hi(4, pg) : 0);
      cmp("cyc_ramwe4", int'(we4), int'(!we_low));
   end

   task automatic bus_idle();
      MREQ_B = 1'b1; IOREQ_B = 1'b1; RD_B = 1'b1; WR_B = 1'b1; M1_B = 1'b1; RFSH_B = 1'b1;
      tb_d_oe = 1'b0;
   endtask

   task automatic mem_rd(input logic [7:0] a, input int dis, input int h3, input int h4);
      $display("txn mem_rd addr=%02h00", a);
      @(posedge CLK); #2;
      A = a; MREQ_B = 1'b0; RD_B = 1'b0;
      #1;
      cmp("rd_ramdis", int'(ramdis3), dis);
      cmp("rd_ramoe", int'(oe3), 1 - dis);
      cmp("rd_hiadr3", int'(hiadr3), h3);
      cmp("rd_hiadr4", int'(hiadr4), h4);
      repeat (2) @(posedge CLK);
      #2 bus_idle();
   endtask

   task automatic mem_wr(input logic [7:0] a, input logic [7:0] d, input bit do_reset);
      int falls0;
      $display("txn mem_wr addr=%02h00 data=%02h reset=%0d", a, d, do_reset);
      falls0 = we_falls;
      @(posedge CLK); #2;
      A = a; tb_d = d; tb_d_oe = 1'b1; MREQ_B = 1'b0; WR_B = 1'b0;
      #1 cmp("wr_we_before_edge", int'(we3), 1);
      @(posedge CLK); #1;
      cmp("wr_we_first_edge", int'(we3), 0);
      if (do_reset) begin
         #1 RESET_B = 1'b0;
         m_mode = 0; m_bank_lo = 0; m_port_a = 255;
         #1 cmp("rst_we_async", int'(we3), 1);
         repeat (2) @(posedge CLK);
         #2 RESET_B = 1'b1;
         #1;
         cmp("rel_ramdis", int'(ramdis3), 0);
         cmp("rel_hiadr", int'(hiadr3), 0);
         cmp("rel_ramcs", int'(cs3), 1);
         cmp("rel_ramwe", int'(we3), 1);
      end else begin
         cmp("wr_hiadr3", int'(hiadr3), exp_hi(3, map_page(a)));
         @(posedge CLK); #1;
         cmp("wr_we_hold", int'(we3), 0);
         #1 WR_B = 1'b1;
         #1 cmp("wr_we_release", int'(we3), 1);
         cmp("wr_pulses", we_falls - falls0, 1);
      end
      @(posedge CLK); #2 bus_idle();
   endtask

   // IOREQ_B stays low for three edges; data switches after the first to catch a second load.
   task automatic io_out(input logic [7:0] a, input logic [7:0] d, input logic [7:0] d2);
      $display("txn io_out port=%02h00 data=%02h then=%02h", a, d, d2);
      @(posedge CLK); #2;
      A = a; tb_d = d; tb_d_oe = 1'b1; IOREQ_B = 1'b0; WR_B = 1'b0;
      @(posedge CLK); #2 tb_d = d2;
      repeat (2) @(posedge CLK);
      #2 bus_idle();
      m_mode = int'(d[2:0]); m_bank_lo = int'(d[5:3]); m_port_a = int'(a);
   endtask

   task automatic int_ack(input logic [7:0] a, input logic [7:0] d);
      $display("txn int_ack addr=%02h00 data=%02h", a, d);
      @(posedge CLK); #2;
      A = a; tb_d = d; tb_d_oe = 1'b1; M1_B = 1'b0; IOREQ_B = 1'b0; WR_B = 1'b0;
      repeat (2) @(posedge CLK);
      #2 bus_idle();
   endtask

   task automatic refresh(input logic [7:0] a);
      $display("txn refresh addr=%02h00", a);
      @(posedge CLK); #2;
      A = a; MREQ_B = 1'b0; RFSH_B = 1'b0;
      #1;
      cmp("rf_ramdis", int'(ramdis3), 0);
      cmp("rf_ramcs", int'(cs3), 1);
      @(posedge CLK); #2 bus_idle();
   endtask

   task automatic io_in(input logic [7:0] a, input int exp);
      $display("txn io_in port=%02h00", a);
      @(posedge CLK); #2;
      A = a; IOREQ_B = 1'b0; RD_B = 1'b0;
      #1 cmp("in_data", int'(d_bus), exp);
      @(posedge CLK); #2 bus_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int rb_exp;
      #1 RESET_B = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      cmp("rst_ramdis", int'(ramdis3), 0);
      cmp("rst_hiadr", int'(hiadr3), 0);
      cmp("rst_ramcs", int'(cs3), 1);
      cmp("rst_ramoe", int'(oe3), 1);
      cmp("rst_ramwe", int'(we3), 1);
      #1 RESET_B = 1'b1;

      mem_rd(8'hC0, 0, 0, 0);
      io_out(8'h7F, 8'hC1, 8'hC1);
      mem_rd(8'hC0, 1, 5'b00011, 6'b000011);
      mem_rd(8'h40, 0, 0, 0);
      refresh(8'hC0);
      io_out(8'h7E, 8'hEE, 8'hEE);
      mem_rd(8'h40, 1, 5'b10110, 6'b110110);
      io_out(8'h7F, 8'hC2, 8'hC7);
      mem_rd(8'h80, 1, 2, 2);
      mem_rd(8'h00, 1, 0, 0);
      mem_wr(8'h80, 8'h5A, 1'b0);
      int_ack(8'h7F, 8'hC1);
      mem_rd(8'h40, 1, 1, 1);
      mem_wr(8'h40, 8'hA5, 1'b1);
      mem_rd(8'hC0, 0, 0, 0);
      io_out(8'h7F, 8'hD5, 8'hD5);
      mem_rd(8'h40, 1, 5'b01001, 6'b001001);

      // Readback decodes only with A14 low, so port 0x7F00 never answers.
      io_in(8'h7F, 8'hFF);
`ifdef CFG_READBACK_EN
      rb_exp = 8'hD5;
`else
      rb_exp = 8'hFF;
`endif
      io_in(8'h3F, rb_exp);

      @(posedge CLK);
      @(negedge CLK);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
